lsu_mmio_fifo: RTL and testbench

//  Parametrised load/store unit for the pipelined core: byte/half/word access to local data RAM

---
 rtl/lsu_mmio_fifo.sv | 185 ++++++++++++++++++
 tb/tb_lsu_mmio_fifo.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_mmio_fifo.sv
// Load/store unit: byte/half/word access to local data RAM plus a 16-byte
// UART register window (TXDATA, RXDATA, STATUS, BAUD) backed by TX/RX FIFOs.
// Every accepted request gets exactly one response on the following cycle.
module lsu_mmio_fifo #(
  parameter int unsigned MEM_WORDS = 256,
  parameter logic [31:0] UART_BASE = 32'h400,
  parameter int unsigned TX_DEPTH  = 8,
  parameter int unsigned RX_DEPTH  = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_uns,
  input  logic [31:0] address,
  input  logic [31:0] data_in,
  output logic        rsp_valid,
  output logic        rsp_err,
  output logic [31:0] data_out,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [9:0]  rx_data,
  input  logic        rx_valid,
  output logic [15:0] brd
);
  localparam int AW  = $clog2(MEM_WORDS);
  localparam int TPW = $clog2(TX_DEPTH);
  localparam int RPW = $clog2(RX_DEPTH);
  localparam logic [TPW:0] TX_FULLC = (TPW+1)'(TX_DEPTH);
  localparam logic [RPW:0] RX_FULLC = (RPW+1)'(RX_DEPTH);
  localparam logic [TPW:0] TX_ONE   = (TPW+1)'(1);
  localparam logic [RPW:0] RX_ONE   = (RPW+1)'(1);

  logic [3:0][7:0] mem_q [MEM_WORDS];
  logic [7:0]      tx_mem_q [TX_DEPTH];
  logic [9:0]      rx_mem_q [RX_DEPTH];
  logic [TPW-1:0]  tx_wp_q, tx_rp_q;
  logic [RPW-1:0]  rx_wp_q, rx_rp_q;
  logic [TPW:0]    tx_cnt_q, tx_cnt_d;
  logic [RPW:0]    rx_cnt_q, rx_cnt_d;
  logic            ovr_q, ovr_d;
  logic [31:0]     baud_q;
  logic            rsp_valid_q, rsp_err_q;
  logic [31:0]     rdata_q, rdata_d;

  logic            ram_hit, uart_hit, mis, err, u_ok, acc;
  logic [1:0]      ureg;
  logic [AW-1:0]   idx;
  logic            tx_full, tx_empty, rx_full, rx_empty;
  logic            tx_wr, rx_rd, tx_push, tx_pop, rx_push, rx_pop, ovr_set, ovr_clr, baud_wr, ram_we;
  logic [3:0]      be;
  logic [31:0]     wlane, word, ld, stat;
  logic [3:0]      txc4, rxc4;

  // Address decode and error classification; RAM takes precedence over the UART window.
  assign ram_hit  = (address >> (AW + 2)) == 32'd0;
  assign uart_hit = address[31:4] == UART_BASE[31:4];
  assign mis      = (req_size == 2'd1 && address[0]) || (req_size == 2'd2 && address[1:0] != 2'd0);
  assign err      = (req_size == 2'd3) || mis || !(ram_hit || uart_hit) ||
                    (!ram_hit && uart_hit && req_size != 2'd2);
  assign u_ok     = !err && !ram_hit;
  assign ureg     = address[3:2];
  assign idx      = address[AW+1:2];

  assign tx_full  = tx_cnt_q == TX_FULLC;
  assign tx_empty = tx_cnt_q == '0;
  assign rx_full  = rx_cnt_q == RX_FULLC;
  assign rx_empty = rx_cnt_q == '0;

  // Stall only on TXDATA write into a full FIFO or RXDATA read from an empty one.
  assign tx_wr     = u_ok && req_we && ureg == 2'd0;
  assign rx_rd     = u_ok && !req_we && ureg == 2'd1;
  assign req_ready = !(req_valid && ((tx_wr && tx_full) || (rx_rd && rx_empty)));
  assign acc       = req_valid && req_ready;

  assign tx_push = acc && tx_wr;
  assign tx_pop  = tx_valid && tx_ready;
  assign rx_pop  = acc && rx_rd;
  assign rx_push = rx_valid && (!rx_full || rx_pop);
  assign ovr_set = rx_valid && rx_full && !rx_pop;
  assign ovr_clr = acc && u_ok && req_we && ureg == 2'd2 && data_in[4];
  assign baud_wr = acc && u_ok && req_we && ureg == 2'd3;
  assign ram_we  = acc && !err && ram_hit && req_we;

  // Store lane enables and lane-replicated write data.
  always_comb begin
    be    = 4'b1111;
    wlane = data_in;
    case (req_size)
      2'd0: begin be = 4'b0001 << address[1:0]; wlane = {4{data_in[7:0]}}; end
      2'd1: begin be = address[1] ? 4'b1100 : 4'b0011; wlane = {2{data_in[15:0]}}; end
      default: ;
    endcase
  end

  // Load path: lane select plus extension, or UART register read.
  always_comb begin
    word = mem_q[idx];
    ld   = word;
    case (req_size)
      2'd0: begin
        ld = word >> {address[1:0], 3'b000};
        ld = req_uns ? {24'd0, ld[7:0]} : {{24{ld[7]}}, ld[7:0]};
      end
      2'd1: begin
        ld = word >> {address[1], 4'b0000};
        ld = req_uns ? {16'd0, ld[15:0]} : {{16{ld[15]}}, ld[15:0]};
      end
      default: ;
    endcase
    txc4 = 4'(tx_cnt_q);
    rxc4 = 4'(rx_cnt_q);
    stat = {16'd0, rxc4, txc4, 3'd0, ovr_q, rx_empty, rx_full, tx_empty, tx_full};
    rdata_d = ld;
    if (!ram_hit) begin
      case (ureg)
        2'd0:    rdata_d = 32'(tx_cnt_q);
        2'd1:    rdata_d = {22'd0, rx_mem_q[rx_rp_q]};
        2'd2:    rdata_d = stat;
        default: rdata_d = baud_q;
      endcase
    end
  end

  // FIFO occupancy and sticky overrun next-state.
  always_comb begin
    tx_cnt_d = tx_cnt_q;
    rx_cnt_d = rx_cnt_q;
    ovr_d    = ovr_q;
    if (tx_push && !tx_pop) tx_cnt_d = tx_cnt_q + TX_ONE;
    if (!tx_push && tx_pop) tx_cnt_d = tx_cnt_q - TX_ONE;
    if (rx_push && !rx_pop) rx_cnt_d = rx_cnt_q + RX_ONE;
    if (!rx_push && rx_pop) rx_cnt_d = rx_cnt_q - RX_ONE;
    if (ovr_clr) ovr_d = 1'b0;
    if (ovr_set) ovr_d = 1'b1;
  end

  // RAM and FIFO storage: data only, never reset.
  always_ff @(posedge clk) begin
    if (ram_we)
      for (int b = 0; b < 4; b++)
        if (be[b]) mem_q[idx][b] <= wlane[b*8 +: 8];
    if (tx_push) tx_mem_q[tx_wp_q] <= data_in[7:0];
    if (rx_push) rx_mem_q[rx_wp_q] <= rx_data;
  end

  // Control state: pointers, counts, BAUD and the one-cycle response register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_wp_q     <= '0;
      tx_rp_q     <= '0;
      rx_wp_q     <= '0;
      rx_rp_q     <= '0;
      tx_cnt_q    <= '0;
      rx_cnt_q    <= '0;
      ovr_q       <= 1'b0;
      baud_q      <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rdata_q     <= '0;
    end else begin
      if (tx_push) tx_wp_q <= tx_wp_q + 1'b1;
      if (tx_pop)  tx_rp_q <= tx_rp_q + 1'b1;
      if (rx_push) rx_wp_q <= rx_wp_q + 1'b1;
      if (rx_pop)  rx_rp_q <= rx_rp_q + 1'b1;
      tx_cnt_q    <= tx_cnt_d;
      rx_cnt_q    <= rx_cnt_d;
      ovr_q       <= ovr_d;
      if (baud_wr) baud_q <= data_in;
      rsp_valid_q <= acc;
      rsp_err_q   <= acc && err;
      rdata_q     <= (acc && !err && !req_we) ? rdata_d : 32'd0;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign data_out  = rdata_q;
  assign tx_valid  = !tx_empty;
  assign tx_data   = tx_mem_q[tx_rp_q];
  assign brd       = baud_q[15:0];
endmodule

// File: tb/tb_lsu_mmio_fifo.sv
// Scoreboard bench for lsu_mmio_fifo: expected responses are queued when a
// request is accepted and compared when rsp_valid pulses.
module tb_lsu_mmio_fifo;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic        req_valid = 1'b0, req_ready, req_we = 1'b0, req_uns = 1'b0;
  logic [1:0]  req_size = 2'd0;
  logic [31:0] address = '0, data_in = '0, data_out;
  logic        rsp_valid, rsp_err;
  logic [7:0]  tx_data;
  logic        tx_valid, tx_ready = 1'b0;
  logic [9:0]  rx_data = '0;
  logic        rx_valid = 1'b0;
  logic [15:0] brd;

  localparam logic [31:0] TXA = 32'h400, RXA = 32'h404, STA = 32'h408, BDA = 32'h40C;

  typedef struct { string name; logic err; logic [31:0] data; } exp_t;
  exp_t exp_q[$];
  exp_t ce;
  int vectors = 0, miscompares = 0;

  lsu_mmio_fifo dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_size(req_size), .req_uns(req_uns), .address(address),
    .data_in(data_in), .rsp_valid(rsp_valid), .rsp_err(rsp_err), .data_out(data_out),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .brd(brd)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  // Response checker
  always @(negedge clk) begin
    if (rst_n && rsp_valid) begin
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL rsp_unexpected: got err=%0b data=%h, required no response", rsp_err, data_out);
      end else begin
        ce = exp_q.pop_front();
        if (rsp_err !== ce.err || data_out !== ce.data) begin
          miscompares++;
          $display("FAIL %s: got err=%0b data=%h, required err=%0b data=%h",
                   ce.name, rsp_err, data_out, ce.err, ce.data);
        end
      end
    end
  end

  task automatic do_req(input string nm, input logic we, input logic [1:0] sz, input logic uns,
                        input logic [31:0] a, input logic [31:0] d,
                        input logic ee, input logic [31:0] ed, input bit keep = 1'b0);
    int t;
    exp_t e;
    t = 0;
    req_valid = 1'b1; req_we = we; req_size = sz; req_uns = uns; address = a; data_in = d;
    @(negedge clk);
    while (!req_ready && t < 200) begin @(negedge clk); t++; end
    if (!req_ready) begin
      vectors++; miscompares++;
      $display("FAIL %s_timeout: req_ready=0, required 1 within 200 cycles", nm);
    end else begin
      e.name = nm; e.err = ee; e.data = ed;
      exp_q.push_back(e);
    end
    @(posedge clk); #1;
    if (!keep) req_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    vectors++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || rsp_err !== 1'b0 || data_out !== 32'd0 ||
        tx_valid !== 1'b0 || brd !== 16'd0) begin
      miscompares++;
      $display("FAIL reset_state: rdy=%b vld=%b err=%b dout=%h txv=%b brd=%h, required 1 0 0 0 0 0",
               req_ready, rsp_valid, rsp_err, data_out, tx_valid, brd);
    end
    @(posedge clk); #1 rst_n = 1'b1;
    do_req("reset_status", 0, 2'd2, 0, STA, 0, 0, 32'h0000_000A);
  endtask

  task automatic test_ram();
    do_req("sw_10",   1, 2'd2, 0, 32'h10,  32'hDEADBEEF, 0, 32'h0);
    do_req("lb_13",   0, 2'd0, 0, 32'h13,  0, 0, 32'hFFFFFFDE);
    do_req("sb_11",   1, 2'd0, 0, 32'h11,  32'h0000005A, 0, 32'h0);
    do_req("lw_10",   0, 2'd2, 0, 32'h10,  0, 0, 32'hDEAD5AEF);
    do_req("lhu_12",  0, 2'd1, 1, 32'h12,  0, 0, 32'h0000DEAD);
    do_req("lh_12",   0, 2'd1, 0, 32'h12,  0, 0, 32'hFFFFDEAD);
    do_req("lbu_10",  0, 2'd0, 1, 32'h10,  0, 0, 32'h000000EF);
    do_req("lb_11",   0, 2'd0, 0, 32'h11,  0, 0, 32'h0000005A);
    do_req("sw_3fc",  1, 2'd2, 0, 32'h3FC, 32'h80000001, 0, 32'h0);
    do_req("lbu_3ff", 0, 2'd0, 1, 32'h3FF, 0, 0, 32'h00000080);
    do_req("lb_3ff",  0, 2'd0, 0, 32'h3FF, 0, 0, 32'hFFFFFF80);
    do_req("sh_12",   1, 2'd1, 0, 32'h12,  32'hFFFF1234, 0, 32'h0);
    do_req("lw_10b",  0, 2'd2, 0, 32'h10,  0, 0, 32'h12345AEF);
  endtask

  task automatic test_errors();
    do_req("lw_mis",    0, 2'd2, 0, 32'h12,  0, 1, 32'h0);
    do_req("sh_mis",    1, 2'd1, 0, 32'h11,  32'hFFFF, 1, 32'h0);
    do_req("sw_mis",    1, 2'd2, 0, 32'h12,  32'h0, 1, 32'h0);
    do_req("size3",     0, 2'd3, 0, 32'h10,  0, 1, 32'h0);
    do_req("lw_unmap",  0, 2'd2, 0, 32'h800, 0, 1, 32'h0);
    do_req("sw_unmap",  1, 2'd2, 0, 32'h800, 32'h1, 1, 32'h0);
    do_req("lw_410",    0, 2'd2, 0, 32'h410, 0, 1, 32'h0);
    do_req("uart_byte", 0, 2'd0, 0, TXA,     0, 1, 32'h0);
    do_req("lw_intact", 0, 2'd2, 0, 32'h10,  0, 0, 32'h12345AEF);
  endtask

  task automatic test_back_to_back();
    do_req("b2b_sw", 1, 2'd2, 0, 32'h20, 32'h11223344, 0, 32'h0, 1'b1);
    do_req("b2b_sh", 1, 2'd1, 0, 32'h22, 32'h0000BEEF, 0, 32'h0, 1'b1);
    do_req("b2b_lw", 0, 2'd2, 0, 32'h20, 0, 0, 32'hBEEF3344, 1'b1);
    do_req("b2b_lb", 0, 2'd0, 0, 32'h20, 0, 0, 32'h00000044, 1'b1);
    do_req("b2b_lh", 0, 2'd1, 0, 32'h22, 0, 0, 32'hFFFFBEEF);
  endtask

  task automatic test_baud();
    do_req("baud_wr", 1, 2'd2, 0, BDA, 32'h000001B2, 0, 32'h0);
    @(negedge clk);
    vectors++;
    if (brd !== 16'h01B2) begin miscompares++; $display("FAIL brd_1b2: got %h, required 01b2", brd); end
    @(posedge clk); #1;
    do_req("baud_rd",  0, 2'd2, 0, BDA, 0, 0, 32'h000001B2);
    do_req("baud_wr2", 1, 2'd2, 0, BDA, 32'hABCD1234, 0, 32'h0);
    do_req("baud_rd2", 0, 2'd2, 0, BDA, 0, 0, 32'hABCD1234);
    vectors++;
    if (brd !== 16'h1234) begin miscompares++; $display("FAIL brd_1234: got %h, required 1234", brd); end
  endtask

  task automatic test_tx_stall();
    exp_t e;
    tx_ready = 1'b0;
    do_req("tx_cnt0", 0, 2'd2, 0, TXA, 0, 0, 32'd0);
    for (int i = 1; i <= 8; i++) do_req("tx_push", 1, 2'd2, 0, TXA, 32'(i), 0, 32'h0);
    do_req("tx_status_full", 0, 2'd2, 0, STA, 0, 0, 32'h0000_0809);
    do_req("tx_cnt8", 0, 2'd2, 0, TXA, 0, 0, 32'd8);
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'd2; address = TXA; data_in = 32'd9;
    repeat (3) begin
      @(negedge clk);
      vectors++;
      if (req_ready !== 1'b0) begin miscompares++; $display("FAIL tx_stall: req_ready=%b, required 0", req_ready); end
    end
    vectors++;
    if (tx_valid !== 1'b1 || tx_data !== 8'd1) begin
      miscompares++; $display("FAIL tx_head: got v=%b d=%h, required v=1 d=01", tx_valid, tx_data);
    end
    @(posedge clk); #1 tx_ready = 1'b1;
    @(posedge clk); #1 tx_ready = 1'b0;
    @(negedge clk);
    vectors++;
    if (req_ready !== 1'b1) begin
      miscompares++; $display("FAIL tx_unstall: req_ready=%b, required 1", req_ready);
    end else begin
      e.name = "tx_push9"; e.err = 1'b0; e.data = 32'h0; exp_q.push_back(e);
    end
    @(posedge clk); #1 req_valid = 1'b0; tx_ready = 1'b1;
    for (int i = 2; i <= 9; i++) begin
      @(negedge clk);
      vectors++;
      if (tx_valid !== 1'b1 || tx_data !== 8'(i)) begin
        miscompares++; $display("FAIL tx_order: got v=%b d=%h, required v=1 d=%h", tx_valid, tx_data, 8'(i));
      end
    end
    @(negedge clk);
    vectors++;
    if (tx_valid !== 1'b0) begin miscompares++; $display("FAIL tx_drained: tx_valid=%b, required 0", tx_valid); end
    tx_ready = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_rx();
    exp_t e;
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'd2; address = RXA;
    @(negedge clk);
    vectors++;
    if (req_ready !== 1'b0) begin miscompares++; $display("FAIL rx_stall: req_ready=%b, required 0", req_ready); end
    @(posedge clk); #1 rx_valid = 1'b1; rx_data = 10'h155;
    @(posedge clk); #1 rx_valid = 1'b0;
    @(negedge clk);
    vectors++;
    if (req_ready !== 1'b1) begin
      miscompares++; $display("FAIL rx_unstall: req_ready=%b, required 1", req_ready);
    end else begin
      e.name = "rx_pop_155"; e.err = 1'b0; e.data = 32'h155; exp_q.push_back(e);
    end
    @(posedge clk); #1 req_valid = 1'b0;
    do_req("rx_write_ign", 1, 2'd2, 0, RXA, 32'h3FF, 0, 32'h0);
    do_req("rx_status_empty", 0, 2'd2, 0, STA, 0, 0, 32'h0000_000A);
    for (int i = 1; i <= 9; i++) begin rx_valid = 1'b1; rx_data = 10'(256 + i); @(posedge clk); #1; end
    rx_valid = 1'b0;
    do_req("rx_status_ovr", 0, 2'd2, 0, STA, 0, 0, 32'h0000_8016);
    do_req("rx_clr_ovr", 1, 2'd2, 0, STA, 32'h10, 0, 32'h0);
    do_req("rx_status_clr", 0, 2'd2, 0, STA, 0, 0, 32'h0000_8006);
    for (int i = 1; i <= 8; i++) do_req("rx_pop", 0, 2'd2, 0, RXA, 0, 0, 32'(256 + i));
    do_req("rx_status_drained", 0, 2'd2, 0, STA, 0, 0, 32'h0000_000A);
    for (int i = 1; i <= 8; i++) begin rx_valid = 1'b1; rx_data = 10'(512 + i); @(posedge clk); #1; end
    rx_valid = 1'b1; rx_data = 10'h2FF;
    do_req("rx_pushpop_full", 0, 2'd2, 0, RXA, 0, 0, 32'h201);
    rx_valid = 1'b0;
    do_req("rx_status_pp", 0, 2'd2, 0, STA, 0, 0, 32'h0000_8006);
    for (int i = 2; i <= 8; i++) do_req("rx_pop2", 0, 2'd2, 0, RXA, 0, 0, 32'(512 + i));
    do_req("rx_pop_2ff", 0, 2'd2, 0, RXA, 0, 0, 32'h2FF);
  endtask

  task automatic test_reset_mid();
    tx_ready = 1'b0;
    for (int i = 1; i <= 8; i++) do_req("txm_push", 1, 2'd2, 0, TXA, 32'(16 + i), 0, 32'h0);
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'd2; address = TXA; data_in = 32'h99;
    @(negedge clk);
    vectors++;
    if (req_ready !== 1'b0) begin miscompares++; $display("FAIL mid_stall: req_ready=%b, required 0", req_ready); end
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if (req_ready !== 1'b1 || tx_valid !== 1'b0 || rsp_valid !== 1'b0 || brd !== 16'd0) begin
      miscompares++;
      $display("FAIL mid_reset: rdy=%b txv=%b vld=%b brd=%h, required 1 0 0 0000", req_ready, tx_valid, rsp_valid, brd);
    end
    req_valid = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    do_req("post_reset_status", 0, 2'd2, 0, STA, 0, 0, 32'h0000_000A);
    do_req("post_reset_baud", 0, 2'd2, 0, BDA, 0, 0, 32'h0);
  endtask

  initial begin
    test_reset();
    test_ram();
    test_errors();
    test_back_to_back();
    test_baud();
    test_tx_stall();
    test_rx();
    test_reset_mid();
    repeat (3) @(negedge clk);
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++; $display("FAIL rsp_missing: %0d responses outstanding, required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
